// File: rtl/vtg_pkg.sv
// vtg_pkg: shared definitions for the video timing generator.
//   vtg_phase_e  - phase of a horizontal or vertical scan {ACTIVE, FP, SYNC, BP}
//   VTG_*        - default 640x480@60 timing constants
//   vtg_clog2    - counter width helper (never returns less than 1)
package vtg_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } vtg_phase_e;

  localparam int unsigned VTG_H_ACTIVE = 640;
  localparam int unsigned VTG_H_FP     = 16;
  localparam int unsigned VTG_H_SYNC   = 96;
  localparam int unsigned VTG_H_BP     = 48;
  localparam int unsigned VTG_V_ACTIVE = 480;
  localparam int unsigned VTG_V_FP     = 10;
  localparam int unsigned VTG_V_SYNC   = 2;
  localparam int unsigned VTG_V_BP     = 33;

  function automatic int unsigned vtg_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vtg_delay.sv
// vtg_delay: DEPTH-deep shift register with clock enable and async reset fill.
//   clk     - clock
//   nreset  - asynchronous active-low reset, loads every stage with RST_VAL
//   en      - shift enable
//   d / q   - WIDTH-bit data in / data delayed by DEPTH enabled shifts
// DEPTH = 0 passes d straight through.
module vtg_delay #(
  parameter int unsigned       DEPTH   = 2,
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_thru
      logic unused_ok;
      assign unused_ok = ^{clk, nreset, en};
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
        end else if (en) begin
          sr[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator (default 640x480).
//   clk, nreset        - clock, asynchronous active-low reset
//   pix_en             - pixel tick; all state holds while low
//   h_cnt, v_cnt       - undelayed pixel column / line number
//   vga_hs, vga_vs     - sync outputs, delayed PIPE ticks, polarity HS_POL/VS_POL
//   vga_blk            - blanking, delayed PIPE ticks
//   frame_start        - one-clk pulse when counters move to (0,0)
//   vblank_irq         - one-clk pulse when counters move to (0,V_ACTIVE)
//   frame_cnt          - 16-bit frame counter, wraps
//   line_cmp, line_irq - line-compare interrupt; present only when the macro
//                        VTG_LINE_IRQ_EN is defined
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VTG_H_ACTIVE,
  parameter int unsigned H_FP     = VTG_H_FP,
  parameter int unsigned H_SYNC   = VTG_H_SYNC,
  parameter int unsigned H_BP     = VTG_H_BP,
  parameter int unsigned V_ACTIVE = VTG_V_ACTIVE,
  parameter int unsigned V_FP     = VTG_V_FP,
  parameter int unsigned V_SYNC   = VTG_V_SYNC,
  parameter int unsigned V_BP     = VTG_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE     = 2,
  localparam int unsigned H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = vtg_clog2(H_TOT),
  localparam int unsigned VW      = vtg_clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blk,
  output logic          frame_start,
  output logic          vblank_irq,
  output logic [15:0]   frame_cnt
`ifdef VTG_LINE_IRQ_EN
  ,
  input  logic [VW-1:0] line_cmp,
  output logic          line_irq
`endif
);

  generate
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
      $fatal(1, "video_timing_gen: timing parameters must all be non-zero");
    end
    if (PIPE > 7) begin : g_bad_pipe
      $fatal(1, "video_timing_gen: PIPE must be in 0..7");
    end
  endgenerate

  // Last count of each phase
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FP_END  = HW'(H_ACTIVE + H_FP - 1);
  localparam logic [HW-1:0] H_SY_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FP_END  = VW'(V_ACTIVE + V_FP - 1);
  localparam logic [VW-1:0] V_SY_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);

  // {hs, vs, blk}, active-high, as held during reset
  localparam logic [2:0] RAW_IDLE = 3'b001;

  vtg_phase_e    h_ph, v_ph, h_ph_nxt, v_ph_nxt;
  logic [HW-1:0] h_cnt_nxt;
  logic [VW-1:0] v_cnt_nxt;
  logic          h_wrap, v_wrap;
  logic [2:0]    raw_nxt, raw_q, raw_dly;

  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    h_cnt_nxt = h_wrap ? '0 : h_cnt + HW'(1);
    v_cnt_nxt = v_cnt;
    if (h_wrap) v_cnt_nxt = v_wrap ? '0 : v_cnt + VW'(1);

    h_ph_nxt = h_ph;
    unique case (h_ph)
      ACTIVE: if (h_cnt == H_ACT_END) h_ph_nxt = FP;
      FP:     if (h_cnt == H_FP_END)  h_ph_nxt = SYNC;
      SYNC:   if (h_cnt == H_SY_END)  h_ph_nxt = BP;
      BP:     if (h_cnt == H_LAST)    h_ph_nxt = ACTIVE;
    endcase

    v_ph_nxt = v_ph;
    if (h_wrap) begin
      unique case (v_ph)
        ACTIVE: if (v_cnt == V_ACT_END) v_ph_nxt = FP;
        FP:     if (v_cnt == V_FP_END)  v_ph_nxt = SYNC;
        SYNC:   if (v_cnt == V_SY_END)  v_ph_nxt = BP;
        BP:     if (v_cnt == V_LAST)    v_ph_nxt = ACTIVE;
      endcase
    end

    raw_nxt = {h_ph_nxt == SYNC, v_ph_nxt == SYNC,
               (h_ph_nxt != ACTIVE) || (v_ph_nxt != ACTIVE)};
  end

  // raw_q tracks the phases but resets to the idle pattern, so blanking
  // reads 1 during reset even though (0,0) is an active pixel.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_ph        <= ACTIVE;
      v_ph        <= ACTIVE;
      raw_q       <= RAW_IDLE;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_cnt_nxt;
        v_cnt       <= v_cnt_nxt;
        h_ph        <= h_ph_nxt;
        v_ph        <= v_ph_nxt;
        raw_q       <= raw_nxt;
        frame_start <= h_wrap && v_wrap;
        vblank_irq  <= h_wrap && (v_cnt == V_ACT_END);
        if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef VTG_LINE_IRQ_EN
  // line_cmp is only looked at on the wrap tick, so mid-line changes
  // apply from the next line on.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= pix_en && h_wrap && (v_cnt_nxt == line_cmp);
    end
  end
`endif

  vtg_delay #(
    .DEPTH   (PIPE),
    .WIDTH   (3),
    .RST_VAL (RAW_IDLE)
  ) u_delay (
    .clk    (clk),
    .nreset (nreset),
    .en     (pix_en),
    .d      (raw_q),
    .q      (raw_dly)
  );

  assign vga_hs  = HS_POL ? raw_dly[2] : ~raw_dly[2];
  assign vga_vs  = VS_POL ? raw_dly[1] : ~raw_dly[1];
  assign vga_blk = raw_dly[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster:
// H = 8+2+3+2 = 15 pixels, V = 6+1+2+1 = 10 lines, 150 ticks per frame,
// PIPE = 3, HS_POL = 1, VS_POL = 0.
module tb_video_timing_gen;

  logic       clk;
  logic       nreset;
  logic       pix_en;
  logic [3:0] h_cnt;
  logic [3:0] v_cnt;
  logic       vga_hs, vga_vs, vga_blk;
  logic       frame_start, vblank_irq;
  logic [15:0] frame_cnt;
  logic [3:0] line_cmp;
  logic       line_irq;

  int n_vec = 0;
  int n_err = 0;

  video_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b0),
    .PIPE     (3)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blk     (vga_blk),
    .frame_start (frame_start),
    .vblank_irq  (vblank_irq),
    .frame_cnt   (frame_cnt)
`ifdef VTG_LINE_IRQ_EN
    ,
    .line_cmp    (line_cmp),
    .line_irq    (line_irq)
`endif
  );

`ifndef VTG_LINE_IRQ_EN
  assign line_irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given pix_en; returns 1 time unit after the edge.
  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first;
    int found;
    int irq_h;
    int irq_v;

    nreset   = 1'b0;
    pix_en   = 1'b0;
    line_cmp = 4'd0;
    repeat (3) step(1'b0);

    // Reset state
    check_val("rst_h_cnt",     32'(h_cnt), 0);
    check_val("rst_v_cnt",     32'(v_cnt), 0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 0);
    check_val("rst_hs",        32'(vga_hs), 0);
    check_val("rst_vs",        32'(vga_vs), 1);
    check_val("rst_blk",       32'(vga_blk), 1);
    check_val("rst_fs",        32'(frame_start), 0);
    check_val("rst_vbi",       32'(vblank_irq), 0);

    nreset = 1'b1;
    step(1'b1);                                   // tick 1
    check_val("k1_h_cnt", 32'(h_cnt), 1);
    check_val("k1_v_cnt", 32'(v_cnt), 0);
    check_val("k1_fs",    32'(frame_start), 0);
    check_val("k1_blk",   32'(vga_blk), 1);
    run(2);                                       // tick 3
    check_val("k3_blk",   32'(vga_blk), 1);
    run(1);                                       // tick 4
    check_val("k4_blk",   32'(vga_blk), 0);
    run(6);                                       // tick 10
    check_val("k10_h_cnt", 32'(h_cnt), 10);
    check_val("k10_blk",   32'(vga_blk), 0);
    run(1);                                       // tick 11: blank from h=8
    check_val("k11_blk",   32'(vga_blk), 1);
    run(1);                                       // tick 12
    check_val("k12_hs",    32'(vga_hs), 0);
    run(1);                                       // tick 13: hs from h=10
    check_val("k13_hs",    32'(vga_hs), 1);
    run(2);                                       // tick 15: line wrap
    check_val("k15_hs",    32'(vga_hs), 1);
    check_val("k15_h_cnt", 32'(h_cnt), 0);
    check_val("k15_v_cnt", 32'(v_cnt), 1);

    cnt = 0;
    for (int k = 16; k <= 30; k++) begin
      step(1'b1);
      if (vga_hs) cnt++;
    end
    check_val("hs_width", 32'(cnt), 3);
    check_val("k30_v_cnt", 32'(v_cnt), 2);

    run(59);                                      // tick 89
    check_val("k89_vbi", 32'(vblank_irq), 0);
    run(1);                                       // tick 90: (0,6)
    check_val("k90_vbi",   32'(vblank_irq), 1);
    check_val("k90_v_cnt", 32'(v_cnt), 6);
    check_val("k90_h_cnt", 32'(h_cnt), 0);
    run(1);
    check_val("k91_vbi", 32'(vblank_irq), 0);

    run(16);                                      // tick 107
    check_val("k107_vs", 32'(vga_vs), 1);
    run(1);                                       // tick 108: vs from v=7
    check_val("k108_vs", 32'(vga_vs), 0);
    run(29);                                      // tick 137
    check_val("k137_vs", 32'(vga_vs), 0);
    run(1);                                       // tick 138
    check_val("k138_vs", 32'(vga_vs), 1);

    run(11);                                      // tick 149
    check_val("k149_fs", 32'(frame_start), 0);
    check_val("k149_fc", 32'(frame_cnt), 0);
    run(1);                                       // tick 150: (0,0)
    check_val("k150_fs",    32'(frame_start), 1);
    check_val("k150_fc",    32'(frame_cnt), 1);
    check_val("k150_h_cnt", 32'(h_cnt), 0);
    check_val("k150_v_cnt", 32'(v_cnt), 0);
    check_val("k150_blk",   32'(vga_blk), 1);

    step(1'b0);                                   // stalled clk
    check_val("stall_fs",    32'(frame_start), 0);
    check_val("stall_h_cnt", 32'(h_cnt), 0);
    check_val("stall_fc",    32'(frame_cnt), 1);

    // pix_en on odd clks only: next frame_start 300 clks later
    cnt   = 0;
    first = 0;
    for (int c = 1; c <= 300; c++) begin
      step(1'(c % 2));
      if (frame_start) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    check_val("half_fs_count", 32'(cnt), 1);
    check_val("half_fs_clk",   32'(first), 299);
    check_val("half_fc",       32'(frame_cnt), 2);

    run(65);                                      // (5,4)
    check_val("pre_rst_h_cnt", 32'(h_cnt), 5);
    check_val("pre_rst_v_cnt", 32'(v_cnt), 4);

    #3;
    nreset = 1'b0;                                // between edges
    #1;
    check_val("async_h_cnt", 32'(h_cnt), 0);
    check_val("async_v_cnt", 32'(v_cnt), 0);
    check_val("async_fc",    32'(frame_cnt), 0);
    check_val("async_blk",   32'(vga_blk), 1);
    check_val("async_hs",    32'(vga_hs), 0);
    check_val("async_vs",    32'(vga_vs), 1);
    step(1'b0);
    nreset = 1'b1;

    found = 0;
    for (int t = 1; t <= 200; t++) begin
      step(1'b1);
      if (t == 1) begin
        check_val("rel_h_cnt", 32'(h_cnt), 1);
        check_val("rel_fs",    32'(frame_start), 0);
      end
      if (frame_start) begin
        found = t;
        break;
      end
    end
    check_val("rel_fs_tick", 32'(found), 150);

`ifdef VTG_LINE_IRQ_EN
    line_cmp = 4'd3;
    cnt   = 0;
    irq_h = -1;
    irq_v = -1;
    for (int t = 0; t < 150; t++) begin
      step(1'b1);
      if (line_irq) begin
        cnt++;
        irq_h = int'(h_cnt);
        irq_v = int'(v_cnt);
      end
    end
    check_val("lirq_count", 32'(cnt), 1);
    check_val("lirq_v_cnt", 32'(irq_v), 3);
    check_val("lirq_h_cnt", 32'(irq_h), 0);

    line_cmp = 4'd12;
    cnt = 0;
    for (int t = 0; t < 150; t++) begin
      step(1'b1);
      if (line_irq) cnt++;
    end
    check_val("lirq_out_of_range", 32'(cnt), 0);
`else
    irq_h = 0;
    irq_v = 0;
    check_val("lirq_absent", 32'(line_irq) + 32'(irq_h) + 32'(irq_v), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
